snowbro2_gfx_arbiter: RTL

Shares one SDRAM bank read port between the four 32-bit graphics ROM requesters of the raizing_video path: sprite GFX, SCR0, SCR1 and SCR2. Each requester holds chip-select and address. The block grants the bank round-robin, issues a 2-word read and packs the 16-bit words into 32 bits. It keeps a one-entry tag/data cache per requester and raises OK while the held address matches. It sits between raizing_video and the bank ports of snowbro2_sdram, in the CLK96 domain.

---
 rtl/snowbro2_pkg.sv | 26 ++
 rtl/snowbro2_rr_pick.sv | 27 ++
 rtl/snowbro2_gfx_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/snowbro2_pkg.sv
// rtl/snowbro2_pkg.sv - shared constants, FSM state type and address helper for snowbro2 arbiters
package snowbro2_pkg;

  localparam int NREQ = 4;
  localparam int AW   = 22;
  localparam int DW   = 32;

  localparam logic [1:0] REQ_GFX  = 2'd0;
  localparam logic [1:0] REQ_SCR0 = 2'd1;
  localparam logic [1:0] REQ_SCR1 = 2'd2;
  localparam logic [1:0] REQ_SCR2 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DAT0,
    ST_DAT1
  } gfx_state_e;

  // 32-bit word address to 16-bit SDRAM word address, wrapping within the bank
  function automatic logic [AW-1:0] ba_word_addr(input logic [AW-1:0] offset,
                                                 input logic [AW-2:0] word_addr);
    return offset + {word_addr, 1'b0};
  endfunction

endpackage

// File: rtl/snowbro2_rr_pick.sv
// rtl/snowbro2_rr_pick.sv - combinational round-robin pick over four needs starting at ptr
module snowbro2_rr_pick
  import snowbro2_pkg::*;
(
  input  logic [NREQ-1:0] need,
  input  logic [1:0]      ptr,
  output logic [1:0]      grant,
  output logic            any
);

  logic [1:0] idx;

  // Walk from the farthest slot back to ptr so the closest needing slot wins.
  always_comb begin
    grant = ptr;
    any   = 1'b0;
    idx   = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (need[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snowbro2_gfx_arbiter.sv
// rtl/snowbro2_gfx_arbiter.sv - round-robin SDRAM read arbiter with one-entry cache per gfx requester
module snowbro2_gfx_arbiter
  import snowbro2_pkg::*;
#(
  parameter logic [AW-1:0] OFFSET = 22'h0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    REQ_CS,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  output logic [NREQ-1:0]    REQ_OK,
  output logic [NREQ*DW-1:0] REQ_DOUT,
  output logic [AW-1:0]      BA_ADDR,
  output logic               BA_RD,
  input  logic               BA_ACK,
  input  logic               BA_DOK,
  input  logic               BA_RDY,
  input  logic [15:0]        DATA_READ
);

  gfx_state_e      state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [AW-1:0]   addr_l_q, addr_l_d;
  logic [AW-1:0]   ba_addr_q, ba_addr_d;
  logic [15:0]     lo_q, lo_d;
  logic [NREQ-1:0] valid_q, valid_d;
  logic [AW-1:0]   tag_q  [NREQ];
  logic [AW-1:0]   tag_d  [NREQ];
  logic [DW-1:0]   data_q [NREQ];
  logic [DW-1:0]   data_d [NREQ];

  logic [AW-1:0]   req_addr [NREQ];
  logic [NREQ-1:0] hit;
  logic [NREQ-1:0] need;
  logic [1:0]      pick;
  logic            pick_any;
  logic            fill_en;
  logic [DW-1:0]   fill_word;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i] = REQ_ADDR[i*AW +: AW];
      hit[i]      = REQ_CS[i] & valid_q[i] & (tag_q[i] == req_addr[i]);
      need[i]     = REQ_CS[i] & ~hit[i];
    end
  end

  always_comb begin
    REQ_DOUT = '0;
    for (int i = 0; i < NREQ; i++) begin
      REQ_DOUT[i*DW +: DW] = data_q[i];
    end
  end

  assign REQ_OK  = hit;
  assign BA_RD   = (state_q == ST_REQ);
  assign BA_ADDR = ba_addr_q;

  snowbro2_rr_pick u_pick (
    .need  (need),
    .ptr   (ptr_q),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_l_d  = addr_l_q;
    ba_addr_d = ba_addr_q;
    lo_d      = lo_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    fill_en   = 1'b0;
    fill_word = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d     = pick;
          ptr_d     = pick + 2'd1;
          addr_l_d  = req_addr[pick];
          ba_addr_d = ba_word_addr(OFFSET, req_addr[pick][AW-2:0]);
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BA_ACK) begin
          // A word arriving with the ack is already word 0 of the burst.
          if (BA_DOK) begin
            lo_d = DATA_READ;
            if (BA_RDY) begin
              fill_en   = 1'b1;
              fill_word = {16'h0, DATA_READ};
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_DAT1;
            end
          end else begin
            state_d = ST_DAT0;
          end
        end
      end
      ST_DAT0: begin
        if (BA_DOK) begin
          lo_d = DATA_READ;
          if (BA_RDY) begin
            fill_en   = 1'b1;
            fill_word = {16'h0, DATA_READ};
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_DAT1;
          end
        end
      end
      ST_DAT1: begin
        if (BA_DOK) begin
          fill_en   = 1'b1;
          fill_word = {DATA_READ, lo_q};
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The fill always uses the address latched at grant, even if the requester moved on.
    if (fill_en) begin
      data_d[gnt_q]  = fill_word;
      tag_d[gnt_q]   = addr_l_q;
      valid_d[gnt_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= 2'd0;
      addr_l_q  <= '0;
      ba_addr_q <= '0;
      lo_q      <= '0;
      valid_q   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_l_q  <= addr_l_d;
      ba_addr_q <= ba_addr_d;
      lo_q      <= lo_d;
      valid_q   <= valid_d;
      for (int i = 0; i < NREQ; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
